// File: rtl/cp0_coprocessor_pkg.sv
// Shared CP0 definitions: register indices, exception codes, field positions
// and the exception handler vector also used by the fetch stage.
package cp0_coprocessor_pkg;

    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;
    localparam logic [4:0] REG_PRID  = 5'd15;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam int IM_LSB  = 10;
    localparam int IP_LSB  = 10;
    localparam int EXL_BIT = 1;
    localparam int IE_BIT  = 0;
    localparam int BD_BIT  = 31;
    localparam int EXC_LSB = 2;
    localparam int EXC_W   = 5;

    localparam logic [31:0] HANDLER_VECTOR = 32'h0000_4180;

endpackage

// File: rtl/cp0_coprocessor.sv
// CP0 responder at the M stage: holds SR/Cause/EPC, raises req for interrupts
// and exceptions, and serves mtc0/mfc0 and eret.
module cp0_coprocessor
    import cp0_coprocessor_pkg::*;
#(
    parameter logic [31:0] PRID     = 32'h2004_0007,
    parameter int          HW_INT_W = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                we,
    input  logic [4:0]          cp0_addr,
    input  logic [31:0]         cp0_wdata,
    output logic [31:0]         cp0_rdata,
    input  logic [31:0]         vpc,
    input  logic                bd_in,
    input  logic [4:0]          exc_code_in,
    input  logic [HW_INT_W-1:0] hw_int,
    input  logic                eret,
    output logic                req,
    output logic [31:0]         epc_out
);

    logic [HW_INT_W-1:0] im;
    logic [HW_INT_W-1:0] ip;
    logic                exl;
    logic                ie;
    logic                bd;
    logic [EXC_W-1:0]    exc_code;
    logic [31:0]         epc;

    logic                int_req;
    logic                exc_req;
    logic [31:0]         sr_value;
    logic [31:0]         cause_value;

    assign int_req = ie & ~exl & (|(hw_int & im));
    assign exc_req = ~exl & (exc_code_in != 5'd0);
    assign req     = ~reset & (int_req | exc_req);
    assign epc_out = epc;

    always_comb begin
        sr_value                          = '0;
        sr_value[IM_LSB +: HW_INT_W]      = im;
        sr_value[EXL_BIT]                 = exl;
        sr_value[IE_BIT]                  = ie;
        cause_value                       = '0;
        cause_value[BD_BIT]               = bd;
        cause_value[IP_LSB +: HW_INT_W]   = ip;
        cause_value[EXC_LSB +: EXC_W]     = exc_code;
    end

    always_comb begin
        cp0_rdata = '0;
        case (cp0_addr)
            REG_SR:    cp0_rdata = sr_value;
            REG_CAUSE: cp0_rdata = cause_value;
            REG_EPC:   cp0_rdata = epc;
            REG_PRID:  cp0_rdata = PRID;
            default:   cp0_rdata = '0;
        endcase
    end

    // A taken request blocks the victim's mtc0 and any eret; interrupts win ExcCode.
    always_ff @(posedge clk) begin
        if (reset) begin
            im       <= '0;
            ip       <= '0;
            exl      <= 1'b0;
            ie       <= 1'b0;
            bd       <= 1'b0;
            exc_code <= '0;
            epc      <= '0;
        end else begin
            ip <= hw_int;
            if (req) begin
                exl      <= 1'b1;
                bd       <= bd_in;
                exc_code <= int_req ? EXC_INT : exc_code_in;
                epc      <= bd_in ? (vpc - 32'd4) : vpc;
            end else begin
                if (we && cp0_addr == REG_SR) begin
                    im  <= cp0_wdata[IM_LSB +: HW_INT_W];
                    exl <= cp0_wdata[EXL_BIT];
                    ie  <= cp0_wdata[IE_BIT];
                end
                if (we && cp0_addr == REG_EPC) begin
                    epc <= cp0_wdata;
                end
                if (eret) begin
                    exl <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_cp0_coprocessor.sv
// Directed bench for cp0_coprocessor: linear stimulus with hand-computed expectations.
module tb_cp0_coprocessor;

    logic        clk;
    logic        reset;
    logic        we;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_wdata;
    logic [31:0] cp0_rdata;
    logic [31:0] vpc;
    logic        bd_in;
    logic [4:0]  exc_code_in;
    logic [5:0]  hw_int;
    logic        eret;
    logic        req;
    logic [31:0] epc_out;

    int checks = 0;
    int errors = 0;

    cp0_coprocessor #(.PRID(32'h2004_0007), .HW_INT_W(6)) dut (
        .clk(clk), .reset(reset), .we(we), .cp0_addr(cp0_addr),
        .cp0_wdata(cp0_wdata), .cp0_rdata(cp0_rdata), .vpc(vpc),
        .bd_in(bd_in), .exc_code_in(exc_code_in), .hw_int(hw_int),
        .eret(eret), .req(req), .epc_out(epc_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
        cp0_addr = a;
        #1;
        check(tag, cp0_rdata, exp);
    endtask

    initial begin
        reset = 1'b1; we = 1'b0; cp0_addr = 5'd0; cp0_wdata = '0;
        vpc = '0; bd_in = 1'b0; exc_code_in = 5'd4; hw_int = '0; eret = 1'b0;
        #2;
        check("req_in_reset", {31'd0, req}, 32'd0);
        tick();
        tick();
        check("req_in_reset2", {31'd0, req}, 32'd0);
        reset = 1'b0; exc_code_in = 5'd0;
        rd("rst_sr", 5'd12, 32'd0);
        rd("rst_cause", 5'd13, 32'd0);
        rd("rst_epc", 5'd14, 32'd0);
        rd("rst_prid", 5'd15, 32'h2004_0007);
        rd("other_reg", 5'd3, 32'd0);
        check("rst_epc_out", epc_out, 32'd0);

        // enable interrupts with a line already pending
        we = 1'b1; cp0_addr = 5'd12; cp0_wdata = 32'h0000_fc01; hw_int = 6'b000100;
        vpc = 32'h0000_2000;
        #1;
        check("req_before_ie", {31'd0, req}, 32'd0);
        tick();
        we = 1'b0;
        #1;
        check("int_req", {31'd0, req}, 32'd1);
        rd("sr_written", 5'd12, 32'h0000_fc01);
        rd("cause_ip", 5'd13, 32'h0000_1000);
        tick();
        rd("int_cause", 5'd13, 32'h0000_1000);
        rd("int_sr_exl", 5'd12, 32'h0000_fc03);
        rd("int_epc", 5'd14, 32'h0000_2000);

        // nested request suppressed while EXL=1
        exc_code_in = 5'd12; vpc = 32'h0000_2100;
        #1;
        check("no_nested", {31'd0, req}, 32'd0);
        tick();
        rd("nested_epc", 5'd14, 32'h0000_2000);
        rd("nested_cause", 5'd13, 32'h0000_1000);

        // eret: epc_out visible in the same cycle
        exc_code_in = 5'd0; eret = 1'b1; hw_int = 6'b000000;
        #1;
        check("eret_epc_out", epc_out, 32'h0000_2000);
        check("eret_req", {31'd0, req}, 32'd0);
        tick();
        eret = 1'b0;
        rd("eret_sr", 5'd12, 32'h0000_fc01);
        rd("eret_cause", 5'd13, 32'h0000_0000);

        // RI in a delay slot
        exc_code_in = 5'd10; vpc = 32'h0000_3008; bd_in = 1'b1;
        #1;
        check("ri_req", {31'd0, req}, 32'd1);
        tick();
        exc_code_in = 5'd0; bd_in = 1'b0;
        rd("bd_epc", 5'd14, 32'h0000_3004);
        rd("bd_cause", 5'd13, 32'h8000_0028);
        rd("bd_sr", 5'd12, 32'h0000_fc03);

        eret = 1'b1;
        tick();
        eret = 1'b0;

        // mtc0 EPC dropped when the victim faults
        we = 1'b1; cp0_addr = 5'd14; cp0_wdata = 32'h0000_3100;
        exc_code_in = 5'd5; vpc = 32'h0000_4000;
        #1;
        check("ades_req", {31'd0, req}, 32'd1);
        tick();
        we = 1'b0; exc_code_in = 5'd0;
        rd("mtc0_suppressed", 5'd14, 32'h0000_4000);
        rd("ades_cause", 5'd13, 32'h0000_0014);

        // Cause is read-only
        we = 1'b1; cp0_addr = 5'd13; cp0_wdata = 32'hffff_ffff;
        tick();
        we = 1'b0;
        rd("cause_ro", 5'd13, 32'h0000_0014);

        // mtc0 EPC: old value visible until the edge
        we = 1'b1; cp0_addr = 5'd14; cp0_wdata = 32'h0000_5555;
        #1;
        check("no_write_through", cp0_rdata, 32'h0000_4000);
        tick();
        we = 1'b0;
        rd("epc_written", 5'd14, 32'h0000_5555);

        eret = 1'b1;
        #1;
        check("eret_epc_out2", epc_out, 32'h0000_5555);
        tick();
        rd("eret2_sr", 5'd12, 32'h0000_fc01);

        // eret coinciding with an interrupt: interrupt wins
        hw_int = 6'b000001; vpc = 32'h0000_6000;
        #1;
        check("eret_int_req", {31'd0, req}, 32'd1);
        tick();
        eret = 1'b0; hw_int = 6'b000000;
        rd("eret_int_sr", 5'd12, 32'h0000_fc03);
        rd("eret_int_epc", 5'd14, 32'h0000_6000);
        rd("eret_int_cause", 5'd13, 32'h0000_0400);

        // reset in the middle of a handler
        reset = 1'b1; exc_code_in = 5'd4;
        #1;
        check("req_reset_mid", {31'd0, req}, 32'd0);
        tick();
        reset = 1'b0; exc_code_in = 5'd0;
        rd("mid_rst_sr", 5'd12, 32'd0);
        check("mid_rst_epc_out", epc_out, 32'd0);
        rd("mid_rst_cause", 5'd13, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
